// File: rtl/dsdmnist_pkg.sv
// dsdmnist post-processing shared types.
// Score/label widths and argmax read-back FSM states.
package dsdmnist_pkg;

  localparam int NUM_CLASS = 10;
  localparam int LABEL_W   = 4;
  localparam int SCORE_W   = 32;

  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic [LABEL_W-1:0]        label_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } argmaxrd_state_t;

  function automatic logic cls_last(input label_t k);
    return k == label_t'(NUM_CLASS - 1);
  endfunction

endpackage

// File: rtl/dsdmnist_argmax10.sv
// Streaming 10-class argmax over a valid-qualified score stream.
// Emits a registered one-cycle label pulse after every tenth score.
module dsdmnist_argmax10
  import dsdmnist_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clr_i,
  input  logic   valid_i,
  input  score_t data_i,
  output logic   lbl_v_o,
  output label_t lbl_o
);

  score_t max_q, max_d;
  label_t idx_q, idx_d;
  label_t k_q, k_d;
  label_t lbl_q, lbl_d;
  logic   lbl_v_q, lbl_v_d;
  logic   take;

  // Strict compare keeps the lowest class on ties.
  always_comb begin
    take    = (k_q == '0) || (data_i > max_q);
    max_d   = max_q;
    idx_d   = idx_q;
    k_d     = k_q;
    lbl_d   = lbl_q;
    lbl_v_d = 1'b0;
    if (clr_i) begin
      max_d = '0;
      idx_d = '0;
      k_d   = '0;
    end else if (valid_i) begin
      if (take) begin
        max_d = data_i;
        idx_d = k_q;
      end
      if (cls_last(k_q)) begin
        k_d     = '0;
        lbl_v_d = 1'b1;
        lbl_d   = idx_d;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      lbl_q   <= '0;
      lbl_v_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      lbl_q   <= lbl_d;
      lbl_v_q <= lbl_v_d;
    end
  end

  assign lbl_v_o = lbl_v_q;
  assign lbl_o   = lbl_q;

endmodule

// File: rtl/dsdmnist_argmaxrd.sv
// Result-buffer read-back with per-image argmax.
// Writes one predicted digit per image into the label buffer.
module dsdmnist_argmaxrd
  import dsdmnist_pkg::*;
#(
  parameter int IMGNUM = 10,
  parameter int OAW    = 10,
  parameter int LAW    = 7
) (
  input  logic               i_CLK,
  input  logic               i_RST_n,
  input  logic               i_START,
  output logic               o_RESULTBUF_EN,
  output logic [OAW-1:0]     o_RESULTBUF_ADDR,
  input  logic [SCORE_W-1:0] i_RESULTBUF_DATA,
  output logic               o_LABELBUF_EN,
  output logic               o_LABELBUF_WE,
  output logic [LAW-1:0]     o_LABELBUF_ADDR,
  output logic [LABEL_W-1:0] o_LABELBUF_DATA,
  output logic               o_BUSY,
  output logic               o_DONE
);

  if (IMGNUM < 1) begin : g_img_chk
    $error("IMGNUM must be at least 1");
  end
  if (IMGNUM * NUM_CLASS > 2 ** OAW) begin : g_oaw_chk
    $error("IMGNUM*10 exceeds result buffer");
  end
  if (IMGNUM > 2 ** LAW) begin : g_law_chk
    $error("IMGNUM exceeds label buffer");
  end

  localparam logic [OAW-1:0] ADDR_LAST =
    OAW'(IMGNUM * NUM_CLASS - 1);
  localparam logic [LAW-1:0] IMG_LAST =
    LAW'(IMGNUM - 1);

  argmaxrd_state_t state_q, state_d;
  logic            en_q, en_d;
  logic [OAW-1:0]  addr_q, addr_d;
  logic [LAW-1:0]  img_q, img_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_v_q;
  logic            clr;
  logic            lbl_v;
  label_t          lbl;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    img_d   = img_q;
    busy_d  = busy_q;
    done_d  = done_q;
    clr     = 1'b0;
    if (lbl_v && (img_q != IMG_LAST)) begin
      img_d = img_q + 1'b1;
    end
    unique case (state_q)
      IDLE, FIN: begin
        if (i_START) begin
          state_d = READ;
          en_d    = 1'b1;
          addr_d  = '0;
          img_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      READ: begin
        if (addr_q == ADDR_LAST) begin
          state_d = DRAIN;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Only the final image's pulse can land here.
        if (lbl_v) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      img_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      img_q   <= img_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_v_q  <= en_q;
    end
  end

  dsdmnist_argmax10 u_argmax (
    .clk_i   (i_CLK),
    .rst_ni  (i_RST_n),
    .clr_i   (clr),
    .valid_i (rd_v_q),
    .data_i  (score_t'(i_RESULTBUF_DATA)),
    .lbl_v_o (lbl_v),
    .lbl_o   (lbl)
  );

  assign o_RESULTBUF_EN   = en_q;
  assign o_RESULTBUF_ADDR = addr_q;
  assign o_LABELBUF_EN    = lbl_v;
  assign o_LABELBUF_WE    = lbl_v;
  assign o_LABELBUF_ADDR  = img_q;
  assign o_LABELBUF_DATA  = lbl;
  assign o_BUSY           = busy_q;
  assign o_DONE           = done_q;

endmodule

// File: tb/tb_dsdmnist_argmaxrd.sv
// Bench for dsdmnist_argmaxrd: cycle model plus directed passes.
// Covers IMGNUM=10 and a single-image instance.
module tb_dsdmnist_argmaxrd;

  localparam int N  = 10;
  localparam int NS = N * 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  logic              rb_en, lb_en, lb_we, busy, done;
  logic [9:0]        rb_addr;
  logic [6:0]        lb_addr;
  logic [3:0]        lb_data;
  logic signed [31:0] rb_data;
  logic signed [31:0] mem [NS];

  logic              rb1_en, lb1_en, lb1_we, busy1, done1;
  logic [9:0]        rb1_addr;
  logic [6:0]        lb1_addr;
  logic [3:0]        lb1_data;
  logic signed [31:0] rb1_data;
  logic signed [31:0] mem1 [10];

  dsdmnist_argmaxrd #(.IMGNUM(N)) dut (
    .i_CLK            (clk),
    .i_RST_n          (rst_n),
    .i_START          (start),
    .o_RESULTBUF_EN   (rb_en),
    .o_RESULTBUF_ADDR (rb_addr),
    .i_RESULTBUF_DATA (rb_data),
    .o_LABELBUF_EN    (lb_en),
    .o_LABELBUF_WE    (lb_we),
    .o_LABELBUF_ADDR  (lb_addr),
    .o_LABELBUF_DATA  (lb_data),
    .o_BUSY           (busy),
    .o_DONE           (done)
  );

  dsdmnist_argmaxrd #(.IMGNUM(1)) dut1 (
    .i_CLK            (clk),
    .i_RST_n          (rst_n),
    .i_START          (start1),
    .o_RESULTBUF_EN   (rb1_en),
    .o_RESULTBUF_ADDR (rb1_addr),
    .i_RESULTBUF_DATA (rb1_data),
    .o_LABELBUF_EN    (lb1_en),
    .o_LABELBUF_WE    (lb1_we),
    .o_LABELBUF_ADDR  (lb1_addr),
    .o_LABELBUF_DATA  (lb1_data),
    .o_BUSY           (busy1),
    .o_DONE           (done1)
  );

  always @(posedge clk) if (rb_en) rb_data <= mem[rb_addr];
  always @(posedge clk) if (rb1_en) rb1_data <= mem1[rb1_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int S = -1000;
  bit act = 1'b0;
  int exp_lbl [N];
  int lbuf [128];

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d cyc %0d", nm, a, e, cyc);
    end
  endtask

  function automatic int argmax(input int n);
    int best;
    best = 0;
    for (int k = 1; k < 10; k++)
      if (mem[n*10+k] > mem[n*10+best]) best = k;
    return best;
  endfunction

  // Model: a start is taken only when no pass is in flight.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      act <= 1'b0;
    end else if (start && (!act || cyc - S + 1 >= NS + 3)) begin
      act <= 1'b1;
      S   <= cyc + 1;
      for (int n = 0; n < N; n++) exp_lbl[n] <= argmax(n);
    end
  end

  always @(negedge clk) begin
    int r;
    bit en_e, lw_e, busy_e, done_e;
    r = cyc - S + 1;
    en_e = 1'b0; lw_e = 1'b0; busy_e = 1'b0; done_e = 1'b0;
    if (rst_n && act) begin
      en_e   = (r >= 1) && (r <= NS);
      lw_e   = (r >= 12) && (r <= NS + 2) && ((r - 12) % 10 == 0);
      busy_e = (r >= 1) && (r <= NS + 2);
      done_e = (r >= NS + 3);
    end
    chk("rb_en", int'(rb_en), int'(en_e));
    chk("lb_en", int'(lb_en), int'(lw_e));
    chk("lb_we", int'(lb_we), int'(lw_e));
    chk("busy", int'(busy), int'(busy_e));
    chk("done", int'(done), int'(done_e));
    if (en_e) chk("rb_addr", int'(rb_addr), r - 1);
    if (lw_e) begin
      chk("lb_addr", int'(lb_addr), (r - 12) / 10);
      chk("lb_data", int'(lb_data), exp_lbl[(r - 12) / 10]);
    end
    if (!rst_n || !act) begin
      chk("idle_rb_addr", int'(rb_addr), 0);
      chk("idle_lb_addr", int'(lb_addr), 0);
      chk("idle_lb_data", int'(lb_data), 0);
    end
    if (lb_en && lb_we) lbuf[lb_addr] = int'(lb_data);
  end

  task automatic fill_a();
    for (int n = 0; n < N; n++)
      for (int k = 0; k < 10; k++)
        mem[n*10+k] = (k == n % 10) ? 1000 + n : k * 3 - 50;
  endtask

  task automatic fill_b();
    int s [10];
    s = '{5, -3, 100, 7, 0, 99, -100, 2, 1, 100};
    for (int k = 0; k < 10; k++) begin
      mem[k]    = 32'sh80000000;
      mem[10+k] = (k == 9) ? -1 : -5;
      mem[20+k] = s[k];
    end
    for (int i = 30; i < NS; i++) mem[i] = $urandom();
  endtask

  task automatic clr_lbuf();
    for (int i = 0; i < 128; i++) lbuf[i] = 15;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    chk("done_timeout", int'(done), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s1 [10];
    int en_cnt, en_first, en_last, w_cnt;
    int w_cyc, w_dat, w_adr, d_first, b_at_d;
    s1 = '{5, -3, 100, 7, 0, 99, -100, 2, 1, 100};
    for (int k = 0; k < 10; k++) mem1[k] = s1[k];
    fill_a();
    clr_lbuf();
    repeat (3) @(negedge clk);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_lb1", int'(lb1_en), 0);
    rst_n = 1'b1;
    @(negedge clk);

    start1 = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start = 1'b0;
    en_cnt = 0; en_first = -1; en_last = -1; w_cnt = 0;
    w_cyc = -1; w_dat = -1; w_adr = -1; d_first = -1; b_at_d = -1;
    for (int c = 1; c <= 16; c++) begin
      if (rb1_en) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (lb1_en && lb1_we) begin
        w_cnt++; w_cyc = c;
        w_dat = int'(lb1_data); w_adr = int'(lb1_addr);
      end
      if (done1 && d_first < 0) begin
        d_first = c; b_at_d = int'(busy1);
      end
      @(negedge clk);
    end
    chk("one_en_cnt", en_cnt, 10);
    chk("one_en_first", en_first, 1);
    chk("one_en_last", en_last, 10);
    chk("one_w_cnt", w_cnt, 1);
    chk("one_w_cyc", w_cyc, 12);
    chk("one_w_data", w_dat, 2);
    chk("one_w_addr", w_adr, 0);
    chk("one_done_cyc", d_first, 13);
    chk("one_busy_at_done", b_at_d, 0);

    wait_done();
    for (int n = 0; n < N; n++) begin
      chk("a_lbuf", lbuf[n], n);
      chk("a_model", exp_lbl[n], n);
    end

    fill_b();
    clr_lbuf();
    repeat (2) @(negedge clk);
    pulse_start();
    chk("b_done_drop", int'(done), 0);
    repeat (38) @(negedge clk);
    pulse_start();
    wait_done();
    chk("b_model0", exp_lbl[0], 0);
    chk("b_model1", exp_lbl[1], 9);
    chk("b_model2", exp_lbl[2], 2);
    for (int n = 0; n < N; n++) chk("b_lbuf", lbuf[n], exp_lbl[n]);

    fill_a();
    clr_lbuf();
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (34) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rb_en", int'(rb_en), 0);
    chk("ar_rb_addr", int'(rb_addr), 0);
    chk("ar_lb_en", int'(lb_en), 0);
    chk("ar_lb_we", int'(lb_we), 0);
    chk("ar_lb_addr", int'(lb_addr), 0);
    chk("ar_lb_data", int'(lb_data), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_lbuf2", lbuf[2], 2);
    chk("ar_lbuf3", lbuf[3], 15);
    pulse_start();
    wait_done();
    for (int n = 0; n < N; n++) chk("c_lbuf", lbuf[n], n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsdmnist_argmaxrd.md
Name: dsdmnist_argmaxrd

Overview:
- Post-processing stage directly downstream of the layer-3 result-buffer writer.
- After the result buffer holds IMGNUM×10 signed 32-bit class scores, this block streams them back out of the buffer and computes a per-image argmax.
- It writes one 4-bit predicted digit per image into a label buffer read by the ARM side, then flags completion.

Parameters:
- IMGNUM, 10, number of images stored in the result buffer (10 scores each).
- OAW, 10, result buffer address width; elaboration error if IMGNUM*10 > 2**OAW.
- LAW, 7, label buffer address width; elaboration error if IMGNUM > 2**LAW.

Ports:
- i_CLK  in  1  single clock, rising edge.
- i_RST_n  in  1  asynchronous, active-low reset.
- i_START  in  1  single-cycle start pulse (driven from the writer's done/interrupt logic).
- o_RESULTBUF_EN  out  1  result buffer read enable.
- o_RESULTBUF_ADDR  out  OAW  result buffer read address.
- i_RESULTBUF_DATA  in  32  signed score; valid exactly one cycle after the EN cycle (registered BRAM read).
- o_LABELBUF_EN  out  1  label buffer enable.
- o_LABELBUF_WE  out  1  label buffer write enable (always equal to EN).
- o_LABELBUF_ADDR  out  LAW  image index being written.
- o_LABELBUF_DATA  out  4  predicted digit, 0..9.
- o_BUSY  out  1  high from the first read until the final label write.
- o_DONE  out  1  level; high after a full pass, held until the next accepted start or reset.

Behaviour:
- Reset (asynchronous, i_RST_n=0):
  - state=IDLE; all address and class counters 0; running max and index 0.
  - Every output is 0.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE or FIN, i_START=1 at edge E:
  - Next state READ.
  - o_DONE clears at E.
  - o_RESULTBUF_EN=1 and ADDR=0 from cycle E+1.
- READ:
  - EN=1 every cycle; ADDR increments by 1 each cycle up to IMGNUM*10-1.
  - ADDR never wraps.
  - The cycle ADDR = IMGNUM*10-1 is the last EN cycle; next state is DRAIN.
- Read pipeline:
  - rd_v = EN delayed by one cycle, used to qualify i_RESULTBUF_DATA.
  - Class counter k runs 0..9 and advances on each rd_v.
  - Image counter n advances when k wraps from 9 to 0.
- Argmax:
  - On rd_v with k==0: max←data, idx←0.
  - On rd_v with k>0: if data > max (signed, strict), then max←data, idx←k.
  - Ties keep the lowest class index.
  - 32'sh80000000 is a legal score; an all-equal image yields label 0.
- Label write:
  - On rd_v with k==9, the final index is resolved combinationally, including the current data.
  - In the next cycle: LABELBUF_EN=WE=1, ADDR=n, DATA=index.
  - This is a one-cycle pulse, exactly once per image.
  - Latency: last score EN at cycle t, data at t+1, label write at t+2.
- DRAIN: waits for the final label write, then goes to FIN.
- FIN:
  - o_DONE=1, o_BUSY=0.
  - Outputs are static; labels stay in the buffer.
- o_BUSY is 1 in READ and DRAIN.
- Timing for start accepted at edge 0:
  - EN cycles 1..IMGNUM*10.
  - Last label write at cycle IMGNUM*10+2.
  - o_DONE=1 from cycle IMGNUM*10+3.
  - Default parameters: writes at 12, 22, …, 102; DONE at 103.
- Boundary conditions:
  - i_START during READ or DRAIN is ignored and does not restart or extend the pass.
  - i_START in FIN starts a new full pass from address 0; previous labels are overwritten in order.
  - Reset mid-pass aborts immediately. A partially written label buffer is permitted; no label pulse is generated after reset.
  - A start pulse in the same cycle as reset release is ignored, because reset dominates.
- All outputs are registered; no combinational path from i_RESULTBUF_DATA to any output.

Decomposition:
- Shared package dsdmnist_pkg:
  - NUM_CLASS=10.
  - LABEL_W=4.
  - SCORE_W=32.
  - typedef logic signed [SCORE_W-1:0] score_t.
  - enum argmaxrd_state_t {IDLE, READ, DRAIN, FIN}.
- One sub-module, dsdmnist_argmax10:
  - Streaming comparator holding max/idx/k.
  - Interface: valid, data → label pulse and label.
  - Reusable by a future on-the-fly variant fed directly by the layer-3 output.

Test Plan:
- IMGNUM=1, scores {5,-3,100,7,0,99,-100,2,1,100} → single label write ADDR=0 DATA=2 at cycle 12; DONE at cycle 13; EN high exactly cycles 1..10.
- Image with all scores = 32'sh80000000, then image with class 9 = -1 and the rest = -5 → labels 0 and 9.
- Default IMGNUM=10, max placed at class (n mod 10) for image n → labels 0..9 at addresses 0..9; write pulses at cycles 12+10n; DONE at 103; BUSY low at 103.
- i_START pulsed again at cycle 40 of a run → no address restart; identical label sequence and timing to the clean run.
- i_RST_n asserted at cycle 35 → all outputs 0 asynchronously; no further label writes; a new i_START after release gives a full correct pass.
- Second i_START while in FIN with changed buffer contents → DONE drops at the start edge; new labels overwrite the old; DONE returns after IMGNUM*10+3 cycles.
